// File: rtl/pa_noc_pkg.sv
// Shared NoC definitions: packet width, port numbering and the XY routing function.
package pa_noc;
    localparam int APB_PACKET_WIDTH = 32;
    localparam int NUM_PORTS        = 5;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_EAST  = 3'd3,
        PORT_WEST  = 3'd4
    } port_t;

    typedef struct packed {
        logic                 drop;
        logic [NUM_PORTS-1:0] req;
    } route_t;

    // Dimension-ordered: resolve the column first, then the row.
    function automatic route_t xy_route(input int unsigned row, input int unsigned col,
                                        input int unsigned router_row, input int unsigned router_col,
                                        input int unsigned grid_width);
        route_t r;
        r.drop = 1'b0;
        r.req  = '0;
        if (row >= grid_width || col >= grid_width) r.drop = 1'b1;
        else if (col > router_col)                   r.req[PORT_EAST]  = 1'b1;
        else if (col < router_col)                   r.req[PORT_WEST]  = 1'b1;
        else if (row > router_row)                   r.req[PORT_SOUTH] = 1'b1;
        else if (row < router_row)                   r.req[PORT_NORTH] = 1'b1;
        else                                         r.req[PORT_LOCAL] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/router_buffered_fifo.sv
// Synchronous FIFO with an exposed head word; pointers carry an extra wrap bit.
module noc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full)  wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop  && !empty) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/router_buffered.sv
// Five-port buffered XY mesh router: input FIFOs, per-output round-robin arbiters
// and a registered output slot per port.
module router_buffered
    import pa_noc::*;
#(
    parameter int unsigned GRID_WIDTH = 4,
    parameter int unsigned ROUTER_ROW = 0,
    parameter int unsigned ROUTER_COL = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                        i_clk,
    input  logic                                        i_srst,
    input  logic [NUM_PORTS-1:0][APB_PACKET_WIDTH-1:0]  i_data,
    input  logic [NUM_PORTS-1:0]                        i_valid,
    output logic [NUM_PORTS-1:0]                        o_ready,
    output logic [NUM_PORTS-1:0][APB_PACKET_WIDTH-1:0]  o_data,
    output logic [NUM_PORTS-1:0]                        o_valid,
    input  logic [NUM_PORTS-1:0]                        i_ready,
    output logic                                        o_drop
);
    localparam int COORD_WIDTH = $clog2(GRID_WIDTH);

    logic [NUM_PORTS-1:0][APB_PACKET_WIDTH-1:0] head;
    logic [NUM_PORTS-1:0]                       full;
    logic [NUM_PORTS-1:0]                       empty;
    logic [NUM_PORTS-1:0]                       pop;
    logic [NUM_PORTS-1:0]                       drop_vec;
    route_t [NUM_PORTS-1:0]                     route;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]        req;    // [output][input]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]        grant;  // [output][input]
    logic                                       drop_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
            noc_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (APB_PACKET_WIDTH)
            ) u_fifo (
                .clk   (i_clk),
                .srst  (i_srst),
                .push  (i_valid[gi]),
                .pop   (pop[gi]),
                .wdata (i_data[gi]),
                .head  (head[gi]),
                .full  (full[gi]),
                .empty (empty[gi])
            );

            assign route[gi] = xy_route(32'(head[gi][2*COORD_WIDTH-1:COORD_WIDTH]),
                                        32'(head[gi][COORD_WIDTH-1:0]),
                                        ROUTER_ROW, ROUTER_COL, GRID_WIDTH);
            assign drop_vec[gi] = !empty[gi] && route[gi].drop;
            assign o_ready[gi]  = !full[gi];
        end
    endgenerate

    always_comb begin
        req = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                req[o][p] = !empty[p] && route[p].req[o];
            end
        end
    end

    // Out-of-grid heads leave without arbitration; each head has one route, so grants never collide.
    always_comb begin
        pop = drop_vec;
        for (int o = 0; o < NUM_PORTS; o++) pop = pop | grant[o];
    end

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            logic [2:0]                  ptr_reg;
            logic                        valid_reg;
            logic [APB_PACKET_WIDTH-1:0] data_reg;
            logic [2:0]                  win;
            logic                        found;
            logic                        can_load;
            logic [NUM_PORTS-1:0]        grant_loc;

            assign can_load  = !valid_reg || i_ready[gi];
            assign grant[gi] = grant_loc;
            assign o_valid[gi] = valid_reg;
            assign o_data[gi]  = data_reg;

            // Scan requesters starting at the pointer; first hit wins.
            always_comb begin
                int idx;
                idx       = 0;
                win       = '0;
                found     = 1'b0;
                grant_loc = '0;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(ptr_reg) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (!found && req[gi][idx]) begin
                        found = 1'b1;
                        win   = 3'(idx);
                    end
                end
                if (found && can_load) grant_loc[win] = 1'b1;
            end

            always_ff @(posedge i_clk) begin
                if (i_srst) begin
                    ptr_reg   <= '0;
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (found && can_load) begin
                    valid_reg <= 1'b1;
                    data_reg  <= head[win];
                    ptr_reg   <= (win == 3'(NUM_PORTS-1)) ? 3'd0 : win + 3'd1;
                end else if (i_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_srst) drop_reg <= 1'b0;
        else        drop_reg <= |drop_vec;
    end

    assign o_drop = drop_reg;
endmodule
